// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM states, default frame width and sclk edge selectors.
package spi_pkg;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  localparam int SPI_WIDTH = 8;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;

endpackage

// File: rtl/spi_slave_if.sv
// Board-level 4-wire SPI bus between a master and the spi_slave peer.
interface spi_slave_if;

  logic sclk;
  logic cs;
  logic mosi;
  logic miso;

  modport master (output sclk, output cs, output mosi, input miso);
  modport slave  (input sclk, input cs, input mosi, output miso);

endinterface

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for one asynchronous pin with rise/fall detection on the synced level.
module spi_sync_edge #(
  parameter int STAGES    = 2,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      prev <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_slave.sv
// SPI slave: oversamples sclk/cs/mosi on clk, deserialises one frame per cs-low window
// and returns a preloaded response word MSB-first on miso.
module spi_slave
  import spi_pkg::*;
#(
  parameter int WIDTH       = SPI_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int SAMPLE_EDGE = EDGE_FALL
) (
  input  logic             clk,
  input  logic             rst,
  spi_slave_if.slave       spi,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_err,
  output logic             busy
);

  localparam int               CW    = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    FULL  = CW'(WIDTH);
  localparam logic [1:0]       FLUSH = 2'(SYNC_STAGES);

  logic s_sclk, sclk_rise, sclk_fall;
  logic s_cs, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic s_mosi, sample_edge, shift_edge;
  logic [1:0] flush_q;
  logic armed_q;

  state_t state_q, state_d;
  logic [WIDTH-1:0] tx_buf_q, tx_buf_d, tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pending_q, pending_d, miso_q, miso_d;
  logic rx_valid_q, rx_valid_d, rx_err_q, rx_err_d;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .d(spi.sclk), .q(s_sclk), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .d(spi.cs), .q(s_cs), .rise(cs_rise), .fall(cs_fall)
  );

  assign s_mosi      = mosi_sync[SYNC_STAGES-1];
  assign sample_edge = (SAMPLE_EDGE == EDGE_FALL) ? sclk_fall : sclk_rise;
  assign shift_edge  = (SAMPLE_EDGE == EDGE_RISE) ? sclk_fall : sclk_rise;

  // After reset the synchronisers hold idle values; a frame may only start once a
  // genuinely idle bus (cs high, sclk low) has been seen, so a cs left low is not a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_sync <= '0;
      flush_q   <= '0;
      armed_q   <= 1'b0;
    end else begin
      mosi_sync[0] <= spi.mosi;
      for (int i = 1; i < SYNC_STAGES; i++) mosi_sync[i] <= mosi_sync[i-1];
      if (flush_q != FLUSH) flush_q <= flush_q + 2'd1;
      else if (s_cs && !s_sclk) armed_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_buf_q   <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
      miso_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_buf_q   <= tx_buf_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      miso_q     <= miso_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
    end
  end

  // miso only advances after its current bit has been sampled, so a leading shift edge
  // (the first rising sclk when sampling on falling) does not drop the MSB.
  always_comb begin
    state_d    = state_q;
    tx_buf_d   = tx_buf_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    cnt_d      = cnt_q;
    pending_d  = pending_q;
    miso_d     = miso_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall && armed_q) begin
          state_d    = ACTIVE;
          tx_shift_d = tx_buf_q;
          miso_d     = tx_buf_q[WIDTH-1];
          cnt_d      = '0;
          pending_d  = 1'b0;
        end else if (tx_load) begin
          tx_buf_d = tx_data;
        end
      end
      ACTIVE: begin
        if (sample_edge && cnt_q < FULL) begin
          rx_shift_d = {rx_shift_q[WIDTH-2:0], s_mosi};
          cnt_d      = cnt_q + CW'(1);
          pending_d  = 1'b1;
        end
        if (shift_edge && pending_q) begin
          tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
          miso_d     = tx_shift_q[WIDTH-2];
          pending_d  = 1'b0;
        end
        if (cs_rise) begin
          if (cnt_d == FULL) begin
            rx_data_d  = rx_shift_d;
            rx_valid_d = 1'b1;
          end else begin
            rx_err_d = 1'b1;
          end
          state_d   = IDLE;
          miso_d    = 1'b0;
          pending_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign spi.miso = miso_q;
  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q == ACTIVE);
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a behavioural SPI master plus a frame-level reference model.
module tb_spi_slave;

  localparam int WIDTH = 8;
  localparam int HALF  = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] tx_data;
  logic             tx_load;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_err;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  int both_cnt  = 0;

  logic [WIDTH-1:0] tx_model = '0;
  logic [WIDTH-1:0] rx_model = '0;

  spi_slave_if spi ();

  spi_slave #(.WIDTH(WIDTH), .SYNC_STAGES(2), .SAMPLE_EDGE(1)) dut (
    .clk(clk), .rst(rst), .spi(spi),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) valid_cnt <= valid_cnt + 1;
    if (rx_err) err_cnt <= err_cnt + 1;
    if (rx_valid && rx_err) both_cnt <= both_cnt + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: response bits seen by the master, MSB first, zeros past the word.
  function automatic logic [15:0] exp_miso(input logic [WIDTH-1:0] tx, input int nbits);
    logic [15:0] r = '0;
    for (int i = 0; i < nbits; i++) r[nbits-1-i] = (i < WIDTH) ? tx[WIDTH-1-i] : 1'b0;
    return r;
  endfunction

  // Reference model: a full frame keeps the first WIDTH bits clocked in.
  function automatic logic [WIDTH-1:0] exp_rx(input logic [15:0] bits, input int nbits);
    logic [15:0] shifted = bits >> (nbits - WIDTH);
    return shifted[WIDTH-1:0];
  endfunction

  task automatic load_tx(input logic [WIDTH-1:0] d);
    tx_data = d;
    tx_load = 1'b1;
    wait_clk(1);
    tx_load = 1'b0;
    tx_model = d;
    wait_clk(1);
  endtask

  task automatic run_frame(input int nbits, input logic [15:0] bits, input bit load_mid,
                           output logic [15:0] miso_seen, output int nvalid, output int nerr,
                           output logic mid_busy, output logic mid_ready);
    int v0 = valid_cnt;
    int e0 = err_cnt;
    miso_seen = '0;
    mid_busy  = 1'b0;
    mid_ready = 1'b1;
    spi.cs = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      spi.mosi = bits[nbits-1-i];
      if (load_mid && i == 3) begin
        tx_data = 8'h77;
        tx_load = 1'b1;
        wait_clk(1);
        tx_load = 1'b0;
        wait_clk(HALF - 1);
      end else begin
        wait_clk(HALF);
      end
      spi.sclk = 1'b1;
      wait_clk(HALF);
      miso_seen[nbits-1-i] = spi.miso;
      if (i == 0) begin
        mid_busy  = busy;
        mid_ready = tx_ready;
      end
      spi.sclk = 1'b0;
      wait_clk(HALF);
    end
    spi.mosi = 1'b0;
    wait_clk(HALF);
    spi.cs = 1'b1;
    wait_clk(8);
    nvalid = valid_cnt - v0;
    nerr   = err_cnt - e0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wait_clk(3);
    n_checks++; if (spi.miso !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_miso got %b want 0", spi.miso); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_rx_data got %h want 00", rx_data); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rx_valid got %b want 0", rx_valid); end
    n_checks++; if (rx_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rx_err got %b want 0", rx_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_tx_ready got %b want 1", tx_ready); end
    rst = 1'b0;
    tx_model = '0;
    rx_model = '0;
    wait_clk(8);
  endtask

  task automatic test_loopback;
    logic [15:0] ms; int nv, ne; logic mb, mr;
    load_tx(8'h3C);
    run_frame(8, 16'h00A5, 1'b0, ms, nv, ne, mb, mr);
    rx_model = exp_rx(16'h00A5, 8);
    n_checks++; if (rx_data !== 8'hA5) begin n_fail++; $display("[TB] FAIL loop_rx_data got %h want a5", rx_data); end
    n_checks++; if (nv !== 1 || ne !== 0) begin n_fail++; $display("[TB] FAIL loop_pulses got valid=%0d err=%0d want 1/0", nv, ne); end
    n_checks++; if (ms[7:0] !== 8'h3C) begin n_fail++; $display("[TB] FAIL loop_miso got %h want 3c", ms[7:0]); end
    n_checks++; if (mb !== 1'b1 || mr !== 1'b0) begin n_fail++; $display("[TB] FAIL loop_mid_busy got busy=%b ready=%b want 1/0", mb, mr); end
    n_checks++; if (busy !== 1'b0 || tx_ready !== 1'b1 || spi.miso !== 1'b0) begin
      n_fail++; $display("[TB] FAIL loop_idle got busy=%b ready=%b miso=%b want 0/1/0", busy, tx_ready, spi.miso); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] ms; int nv, ne; logic mb, mr;
    logic [7:0] words [2] = '{8'h01, 8'hFF};
    foreach (words[k]) begin
      run_frame(8, {8'h00, words[k]}, 1'b0, ms, nv, ne, mb, mr);
      rx_model = exp_rx({8'h00, words[k]}, 8);
      n_checks++; if (rx_data !== rx_model || nv !== 1 || ne !== 0) begin
        n_fail++; $display("[TB] FAIL b2b_rx[%0d] got %h v=%0d e=%0d want %h 1/0", k, rx_data, nv, ne, rx_model); end
      n_checks++; if (ms !== exp_miso(tx_model, 8)) begin
        n_fail++; $display("[TB] FAIL b2b_miso[%0d] got %h want %h", k, ms, exp_miso(tx_model, 8)); end
    end
  endtask

  task automatic test_abort;
    logic [15:0] ms; int nv, ne; logic mb, mr;
    run_frame(5, 16'h0015, 1'b0, ms, nv, ne, mb, mr);
    n_checks++; if (nv !== 0 || ne !== 1) begin n_fail++; $display("[TB] FAIL abort_pulses got valid=%0d err=%0d want 0/1", nv, ne); end
    n_checks++; if (rx_data !== rx_model) begin n_fail++; $display("[TB] FAIL abort_rx_data got %h want %h", rx_data, rx_model); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_busy got %b want 0", busy); end
  endtask

  task automatic test_overrun;
    logic [15:0] ms; int nv, ne; logic mb, mr;
    run_frame(10, 16'h03FF, 1'b0, ms, nv, ne, mb, mr);
    rx_model = exp_rx(16'h03FF, 10);
    n_checks++; if (rx_data !== 8'hFF || nv !== 1 || ne !== 0) begin
      n_fail++; $display("[TB] FAIL overrun_rx got %h v=%0d e=%0d want ff 1/0", rx_data, nv, ne); end
    n_checks++; if (ms[1:0] !== 2'b00 || ms !== exp_miso(tx_model, 10)) begin
      n_fail++; $display("[TB] FAIL overrun_miso got %h want %h", ms, exp_miso(tx_model, 10)); end
  endtask

  task automatic test_tx_load;
    logic [15:0] ms; int nv, ne; logic mb, mr;
    run_frame(8, 16'h0012, 1'b1, ms, nv, ne, mb, mr);
    rx_model = 8'h12;
    n_checks++; if (ms !== exp_miso(tx_model, 8)) begin n_fail++; $display("[TB] FAIL busyload_frame_miso got %h want %h", ms, exp_miso(tx_model, 8)); end
    run_frame(8, 16'h0034, 1'b0, ms, nv, ne, mb, mr);
    rx_model = 8'h34;
    n_checks++; if (ms[7:0] !== 8'h3C) begin n_fail++; $display("[TB] FAIL busyload_ignored got %h want 3c", ms[7:0]); end
    load_tx(8'h77);
    run_frame(8, 16'h0056, 1'b0, ms, nv, ne, mb, mr);
    rx_model = 8'h56;
    n_checks++; if (ms !== 16'h0077) begin n_fail++; $display("[TB] FAIL idleload_miso got %h want 0077", ms); end
    n_checks++; if (rx_data !== rx_model) begin n_fail++; $display("[TB] FAIL idleload_rx got %h want %h", rx_data, rx_model); end
  endtask

  task automatic test_reset_mid_frame;
    logic [15:0] ms; int nv, ne; logic mb, mr;
    int v0 = valid_cnt;
    int e0 = err_cnt;
    spi.cs = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 4; i++) begin
      spi.mosi = 1'b1; wait_clk(HALF);
      spi.sclk = 1'b1; wait_clk(HALF);
      spi.sclk = 1'b0; wait_clk(HALF);
    end
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    tx_model = '0;
    rx_model = '0;
    n_checks++; if (busy !== 1'b0 || tx_ready !== 1'b1 || spi.miso !== 1'b0 || rx_data !== 8'h00) begin
      n_fail++; $display("[TB] FAIL midrst_outputs got busy=%b ready=%b miso=%b rx=%h want 0/1/0/00", busy, tx_ready, spi.miso, rx_data); end
    wait_clk(10);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_cs_low_busy got %b want 0", busy); end
    spi.cs = 1'b1;
    spi.mosi = 1'b0;
    wait_clk(10);
    n_checks++; if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 0) begin
      n_fail++; $display("[TB] FAIL midrst_pulses got valid=%0d err=%0d want 0/0", valid_cnt - v0, err_cnt - e0); end
    run_frame(8, 16'h005A, 1'b0, ms, nv, ne, mb, mr);
    rx_model = 8'h5A;
    n_checks++; if (ms !== exp_miso(tx_model, 8) || rx_data !== rx_model || nv !== 1) begin
      n_fail++; $display("[TB] FAIL midrst_next_frame got miso=%h rx=%h v=%0d want %h %h 1", ms, rx_data, nv, exp_miso(tx_model, 8), rx_model); end
  endtask

  task automatic test_random;
    logic [15:0] ms, bits; int nv, ne, nbits; logic mb, mr;
    for (int f = 0; f < 8; f++) begin
      if ($urandom_range(1, 0) == 1) load_tx(8'($urandom));
      nbits = $urandom_range(11, 3);
      bits  = 16'($urandom) & 16'((1 << nbits) - 1);
      run_frame(nbits, bits, 1'b0, ms, nv, ne, mb, mr);
      if (nbits >= WIDTH) rx_model = exp_rx(bits, nbits);
      n_checks++; if (rx_data !== rx_model) begin n_fail++; $display("[TB] FAIL rand_rx[%0d] n=%0d got %h want %h", f, nbits, rx_data, rx_model); end
      n_checks++; if (nv !== (nbits >= WIDTH ? 1 : 0) || ne !== (nbits >= WIDTH ? 0 : 1)) begin
        n_fail++; $display("[TB] FAIL rand_pulses[%0d] n=%0d got v=%0d e=%0d", f, nbits, nv, ne); end
      n_checks++; if (ms !== exp_miso(tx_model, nbits)) begin
        n_fail++; $display("[TB] FAIL rand_miso[%0d] n=%0d got %h want %h", f, nbits, ms, exp_miso(tx_model, nbits)); end
    end
    n_checks++; if (both_cnt !== 0) begin n_fail++; $display("[TB] FAIL valid_err_overlap got %0d want 0", both_cnt); end
  endtask

  initial begin
    rst      = 1'b1;
    spi.cs   = 1'b1;
    spi.sclk = 1'b0;
    spi.mosi = 1'b0;
    tx_data  = '0;
    tx_load  = 1'b0;
    test_reset();
    test_loopback();
    test_back_to_back();
    test_abort();
    test_overrun();
    test_tx_load();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
